reflet_pwm_multi: RTL and testbench

Multi-channel PWM generator and parametrised successor of the single-channel PWM core. All channels share one period counter, one prescaler and one period value. Each channel has its own duty cycle and output polarity. Duty, period and mode pass through shadow registers so updates never glitch a running period. Sits behind the peripheral register interface and drives GPIO pins directly.

---
 rtl/reflet_pwm_multi_if.sv | 26 ++
 rtl/reflet_pwm_multi.sv | 129 ++++++++++++
 tb/tb_reflet_pwm_multi.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reflet_pwm_multi_if.sv
// Configuration and pin bundle of the multi-channel PWM block.
// Master side is the register file / bench, slave side is the PWM core.
interface reflet_pwm_multi_if #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int PRESC_WIDTH = 8
);
  logic                      enable;
  logic [PRESC_WIDTH-1:0]    presc;
  logic [WIDTH-1:0]          max;
  logic                      center;
  logic [CHANNELS*WIDTH-1:0] duty;
  logic [CHANNELS-1:0]       invert;
  logic [CHANNELS-1:0]       out;
  logic                      period_start;

  modport master (
    output enable, presc, max, center, duty, invert,
    input  out, period_start
  );

  modport slave (
    input  enable, presc, max, center, duty, invert,
    output out, period_start
  );
endinterface

// File: rtl/reflet_pwm_multi.sv
// Multi-channel PWM: shared prescaler/counter/period, per-channel duty and polarity.
// Latency: outputs registered, 1 clk after the counter value they reflect.
// Backpressure: none; free-running, settings are shadowed at each period start.
module reflet_pwm_multi #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int PRESC_WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  reflet_pwm_multi_if.slave bus
);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  logic [PRESC_WIDTH-1:0]    presc_cnt;
  logic [WIDTH-1:0]          cnt;
  logic [WIDTH-1:0]          cnt_nxt;
  dir_t                      dir_q;
  dir_t                      dir_nxt;

  logic [WIDTH-1:0]          sh_max;
  logic                      sh_center;
  logic [CHANNELS*WIDTH-1:0] sh_duty;

  logic                      tick;
  logic                      reload;
  logic [WIDTH-1:0]          eff_max;
  logic                      eff_center;
  logic [CHANNELS*WIDTH-1:0] eff_duty;
  logic [WIDTH-1:0]          cnt_last;
  logic [CHANNELS-1:0]       raw;

  logic [CHANNELS-1:0]       out_q;
  logic                      period_start_q;

  // >= keeps the prescaler bounded even if presc is lowered below the running count
  assign tick   = (presc_cnt >= bus.presc);
  assign reload = tick && (cnt == '0) && (dir_q == DIR_UP);

  // The reload tick already acts on the freshly loaded settings
  assign eff_max    = reload ? bus.max    : sh_max;
  assign eff_center = reload ? bus.center : sh_center;
  assign eff_duty   = reload ? bus.duty   : sh_duty;
  assign cnt_last   = eff_max - WIDTH'(1);

  always_comb begin
    raw = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      raw[i] = (eff_max != '0) && (cnt < eff_duty[i*WIDTH +: WIDTH]);
    end
  end

  // Direction/counter next state; endpoints repeat once in center mode
  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir_q;
    if (eff_max == '0) begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end else if (!eff_center) begin
      dir_nxt = DIR_UP;
      cnt_nxt = (cnt >= cnt_last) ? '0 : cnt + WIDTH'(1);
    end else begin
      case (dir_q)
        DIR_UP: begin
          if (cnt >= cnt_last) dir_nxt = DIR_DOWN;
          else                 cnt_nxt = cnt + WIDTH'(1);
        end
        DIR_DOWN: begin
          if (cnt == '0) dir_nxt = DIR_UP;
          else           cnt_nxt = cnt - WIDTH'(1);
        end
        default: begin
          cnt_nxt = '0;
          dir_nxt = DIR_UP;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_q <= DIR_UP;
    end else if (!bus.enable) begin
      dir_q <= DIR_UP;
    end else if (tick) begin
      dir_q <= dir_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_cnt      <= '0;
      cnt            <= '0;
      sh_max         <= '0;
      sh_center      <= 1'b0;
      sh_duty        <= '0;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else if (!bus.enable) begin
      presc_cnt      <= '0;
      cnt            <= '0;
      sh_max         <= bus.max;
      sh_center      <= bus.center;
      sh_duty        <= bus.duty;
      out_q          <= bus.invert;
      period_start_q <= 1'b0;
    end else begin
      out_q          <= raw ^ bus.invert;
      period_start_q <= reload;
      if (reload) begin
        sh_max    <= bus.max;
        sh_center <= bus.center;
        sh_duty   <= bus.duty;
      end
      if (tick) begin
        presc_cnt <= '0;
        cnt       <= cnt_nxt;
      end else begin
        presc_cnt <= presc_cnt + PRESC_WIDTH'(1);
      end
    end
  end

  assign bus.out          = out_q;
  assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_reflet_pwm_multi.sv
// Scoreboard bench for reflet_pwm_multi: period-position reference model feeds a
// queue of expected pin values, a monitor compares them every cycle.
module tb_reflet_pwm_multi;
  localparam int W  = 8;
  localparam int CH = 4;
  localparam int PW = 8;

  logic clk;
  logic reset;

  reflet_pwm_multi_if #(.WIDTH(W), .CHANNELS(CH), .PRESC_WIDTH(PW)) bus ();

  reflet_pwm_multi #(.WIDTH(W), .CHANNELS(CH), .PRESC_WIDTH(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position inside the period, counter derived arithmetically
  logic [CH:0] exp_q[$];
  int m_pc, m_pos, m_max, m_cen;
  int m_duty[CH];

  task automatic load_shadows();
    m_max = int'(bus.max);
    m_cen = int'(bus.center);
    for (int i = 0; i < CH; i++) m_duty[i] = int'(bus.duty[i*W +: W]);
  endtask

  always @(posedge clk) begin
    logic [CH:0] e;
    int c;
    bit tk;
    bit ps;
    e = '0;
    if (!reset) begin
      m_pc = 0; m_pos = 0; m_max = 0; m_cen = 0;
      for (int i = 0; i < CH; i++) m_duty[i] = 0;
    end else if (!bus.enable) begin
      m_pc = 0; m_pos = 0;
      load_shadows();
      e = {1'b0, bus.invert};
    end else begin
      tk = (m_pc == int'(bus.presc));
      ps = 1'b0;
      if (tk && m_pos == 0) begin
        load_shadows();
        ps = 1'b1;
      end
      if (m_max == 0)                       c = 0;
      else if (m_cen == 0 || m_pos < m_max) c = m_pos;
      else                                  c = 2*m_max - 1 - m_pos;
      for (int i = 0; i < CH; i++)
        e[i] = ((m_max != 0) && (c < m_duty[i])) ^ bus.invert[i];
      e[CH] = ps;
      if (tk) begin
        m_pc = 0;
        if (m_max == 0) m_pos = 0;
        else            m_pos = (m_pos + 1) % (m_cen != 0 ? 2*m_max : m_max);
      end else begin
        m_pc++;
      end
    end
    exp_q.push_back(e);
  end

  initial begin
    logic [CH:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("cycle {period_start,out}", {bus.period_start, bus.out}, e);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_ps(input int limit);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!bus.period_start && k < limit);
    chk("period_start_seen", bus.period_start, 1);
  endtask

  // Samples n cycles starting with the current sample point
  task automatic count_high(input int ch, input int n, output int hi, output int psn);
    hi = 0;
    psn = 0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      hi  += int'(bus.out[ch]);
      psn += int'(bus.period_start);
    end
  endtask

  task automatic set_duty(input int ch, input int v);
    bus.duty[ch*W +: W] = W'(v);
  endtask

  int hi, psn, pat;
  int sweep[6] = '{0, 3, 9, 10, 11, 1};

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0; bus.presc = '0; bus.max = '0; bus.center = 1'b0;
    bus.duty = '0; bus.invert = '0;
    #2 reset = 1'b0;
    #1;
    chk("reset_out", bus.out, 0);
    chk("reset_period_start", bus.period_start, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Edge mode, max=10, duty sweep on channel 0
    @(negedge clk);
    bus.max = 8'd10;
    bus.enable = 1'b1;
    foreach (sweep[s]) begin
      set_duty(0, sweep[s]);
      wait_ps(25);
      count_high(0, 10, hi, psn);
      chk($sformatf("edge_high_duty%0d", sweep[s]), hi, (sweep[s] > 10) ? 10 : sweep[s]);
      chk("edge_ps_per_period", psn, 1);
    end
    bus.invert[0] = 1'b1;
    set_duty(0, 3);
    wait_ps(25);
    count_high(0, 10, hi, psn);
    chk("edge_inverted_high", hi, 7);
    bus.invert[0] = 1'b0;

    // Mid-period duty change is deferred to the next period
    set_duty(1, 2);
    wait_ps(25);
    wait_ps(25);
    count_high(1, 5, hi, psn);
    set_duty(1, 7);
    count_high(1, 5, pat, psn);
    chk("deferred_duty_cur_period", hi + pat, 2);
    wait_ps(5);
    count_high(1, 10, hi, psn);
    chk("deferred_duty_next_period", hi, 7);

    // Center mode, max=5, duty2=2
    bus.center = 1'b1;
    bus.max = 8'd5;
    set_duty(2, 2);
    wait_ps(30);
    wait_ps(30);
    pat = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      pat = (pat << 1) | int'(bus.out[2]);
    end
    chk("center_pattern", pat, 10'b1100000011);

    // Prescaled edge mode, then a mid-period disable
    @(negedge clk);
    bus.enable = 1'b0;
    bus.presc = 8'd3; bus.max = 8'd4; bus.center = 1'b0;
    set_duty(3, 1);
    @(negedge clk);
    bus.enable = 1'b1;
    wait_ps(40);
    count_high(3, 16, hi, psn);
    chk("presc_high_of_16", hi, 4);
    chk("presc_ps_of_16", psn, 1);
    repeat (6) @(negedge clk);
    bus.enable = 1'b0;
    bus.invert = 4'b0110;
    @(posedge clk);
    #1;
    chk("disable_out_is_invert", bus.out, 4'b0110);
    chk("disable_ps_low", bus.period_start, 0);
    @(negedge clk);
    bus.enable = 1'b1;
    wait_ps(8);
    count_high(3, 16, hi, psn);
    chk("restart_high_of_16", hi, 4);

    // Async reset mid-period
    bus.invert = 4'b1111;
    repeat (7) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("async_reset_out", bus.out, 0);
    chk("async_reset_ps", bus.period_start, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    // Randomized segments checked by the scoreboard
    for (int s = 0; s < 40; s++) begin
      int r;
      @(negedge clk);
      r = $urandom_range(0, 9);
      if (r == 0) begin
        reset = 1'b0;
        #1;
        chk("rand_async_reset", {bus.period_start, bus.out}, 0);
        @(negedge clk);
        reset = 1'b1;
      end else if (r < 3) begin
        bus.enable = 1'b0;
        bus.presc = PW'($urandom_range(0, 3));
        @(negedge clk);
        bus.enable = 1'b1;
      end
      bus.max = W'($urandom_range(0, 12));
      bus.center = 1'($urandom_range(0, 1));
      bus.invert = CH'($urandom_range(0, 15));
      for (int i = 0; i < CH; i++) set_duty(i, $urandom_range(0, 14));
      repeat ($urandom_range(5, 60)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
